// File: rtl/bp_cce_gad_stream.sv
// bp_cce_gad_stream
//
// Streaming GAD (gather and decide) block for the CCE. It accepts a request
// context, then collects the per-LCE directory entries of one way-group as a
// series of row beats, row_width_p LCEs per beat. After the last beat it
// presents the GAD decision, held stable, until the CCE pops it.
//
// Ports
//   clk_i, reset_n_i      clock, synchronous active-low reset
//   start_v_i / start_ready_o
//                         request context handshake (accepted in IDLE only)
//   req_lce_i, req_wr_i, lru_dirty_i, lru_cached_excl_i
//                         request context fields, captured at start
//   row_v_i / row_ready_o one directory row beat (accepted in SCAN only)
//   row_hits_i, row_ways_i, row_states_i
//                         per-entry hit, way and state {dirty, owned, shared}
//   v_o / yumi_i          result valid / result consumed
//   req_addr_way_o, owner_lce_o, owner_way_o, *_flag_o, inv_lce_o, sharer_cnt_o
//                         GAD result, driven only from registered state
module bp_cce_gad_stream #(
    parameter int num_lce_p      = 8,
    parameter int lce_assoc_p    = 8,
    parameter int lce_id_width_p = 4,
    parameter int row_width_p    = 2,
    parameter int downgrade_en_p = 1,
    localparam int way_w         = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
    localparam int cnt_w         = $clog2(num_lce_p + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    input  logic                           start_v_i,
    output logic                           start_ready_o,
    input  logic [lce_id_width_p-1:0]      req_lce_i,
    input  logic                           req_wr_i,
    input  logic                           lru_dirty_i,
    input  logic                           lru_cached_excl_i,

    input  logic                           row_v_i,
    output logic                           row_ready_o,
    input  logic [row_width_p-1:0]         row_hits_i,
    input  logic [row_width_p*way_w-1:0]   row_ways_i,
    input  logic [row_width_p*3-1:0]       row_states_i,

    output logic                           v_o,
    input  logic                           yumi_i,
    output logic [way_w-1:0]               req_addr_way_o,
    output logic [lce_id_width_p-1:0]      owner_lce_o,
    output logic [way_w-1:0]               owner_way_o,
    output logic                           transfer_flag_o,
    output logic                           replacement_flag_o,
    output logic                           upgrade_flag_o,
    output logic                           invalidate_flag_o,
    output logic                           downgrade_flag_o,
    output logic                           cached_flag_o,
    output logic                           cached_exclusive_flag_o,
    output logic                           cached_owned_flag_o,
    output logic                           cached_dirty_flag_o,
    output logic [num_lce_p-1:0]           inv_lce_o,
    output logic [cnt_w-1:0]               sharer_cnt_o
);

    localparam int lce_idx_w = (num_lce_p > 1) ? $clog2(num_lce_p) : 1;
    localparam int rows_lp   = (num_lce_p + row_width_p - 1) / row_width_p;
    localparam int row_cnt_w = (rows_lp > 1) ? $clog2(rows_lp) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e                           state_q, state_d;
    logic [lce_idx_w-1:0]             req_idx_q, req_idx_d;
    logic                             req_wr_q, req_wr_d;
    logic                             lru_dirty_q, lru_dirty_d;
    logic                             lru_cached_excl_q, lru_cached_excl_d;
    logic [row_cnt_w-1:0]             row_cnt_q, row_cnt_d;
    logic [num_lce_p-1:0]             hit_q, hit_d;
    logic [num_lce_p-1:0]             shared_q, shared_d;
    logic [num_lce_p-1:0]             owned_q, owned_d;
    logic [num_lce_p-1:0]             dirty_q, dirty_d;
    logic [num_lce_p-1:0][way_w-1:0]  way_q, way_d;
    logic                             start_ready_q, start_ready_d;
    logic                             row_ready_q, row_ready_d;
    logic                             v_q, v_d;

    // Only the low bits of the LCE ID select an LCE; the rest are don't-care.
    logic unused_req_lce;
    assign unused_req_lce = ^req_lce_i;

    always_comb begin
        state_d           = state_q;
        req_idx_d         = req_idx_q;
        req_wr_d          = req_wr_q;
        lru_dirty_d       = lru_dirty_q;
        lru_cached_excl_d = lru_cached_excl_q;
        row_cnt_d         = row_cnt_q;
        hit_d             = hit_q;
        shared_d          = shared_q;
        owned_d           = owned_q;
        dirty_d           = dirty_q;
        way_d             = way_q;

        case (state_q)
            IDLE: begin
                if (start_v_i) begin
                    req_idx_d         = req_lce_i[lce_idx_w-1:0];
                    req_wr_d          = req_wr_i;
                    lru_dirty_d       = lru_dirty_i;
                    lru_cached_excl_d = lru_cached_excl_i;
                    row_cnt_d         = '0;
                    hit_d             = '0;
                    shared_d          = '0;
                    owned_d           = '0;
                    dirty_d           = '0;
                    way_d             = '0;
                    state_d           = SCAN;
                end
            end
            SCAN: begin
                if (row_v_i) begin
                    // LCE i lives in row i/row_width_p, slot i%row_width_p.
                    // Slots past num_lce_p in the last row have no LCE and
                    // are simply never selected.
                    for (int i = 0; i < num_lce_p; i++) begin
                        if (row_cnt_q == row_cnt_w'(i / row_width_p)) begin
                            hit_d[i]    = row_hits_i[i % row_width_p];
                            way_d[i]    = row_ways_i[(i % row_width_p)*way_w +: way_w];
                            shared_d[i] = row_states_i[(i % row_width_p)*3 + 0];
                            owned_d[i]  = row_states_i[(i % row_width_p)*3 + 1];
                            dirty_d[i]  = row_states_i[(i % row_width_p)*3 + 2];
                        end
                    end
                    row_cnt_d = row_cnt_q + 1'b1;
                    if (row_cnt_q == row_cnt_w'(rows_lp - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered from the next state.
        start_ready_d = (state_d == IDLE);
        row_ready_d   = (state_d == SCAN);
        v_d           = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q           <= IDLE;
            req_idx_q         <= '0;
            req_wr_q          <= 1'b0;
            lru_dirty_q       <= 1'b0;
            lru_cached_excl_q <= 1'b0;
            row_cnt_q         <= '0;
            hit_q             <= '0;
            shared_q          <= '0;
            owned_q           <= '0;
            dirty_q           <= '0;
            way_q             <= '0;
            start_ready_q     <= 1'b1;
            row_ready_q       <= 1'b0;
            v_q               <= 1'b0;
        end else begin
            state_q           <= state_d;
            req_idx_q         <= req_idx_d;
            req_wr_q          <= req_wr_d;
            lru_dirty_q       <= lru_dirty_d;
            lru_cached_excl_q <= lru_cached_excl_d;
            row_cnt_q         <= row_cnt_d;
            hit_q             <= hit_d;
            shared_q          <= shared_d;
            owned_q           <= owned_d;
            dirty_q           <= dirty_d;
            way_q             <= way_d;
            start_ready_q     <= start_ready_d;
            row_ready_q       <= row_ready_d;
            v_q               <= v_d;
        end
    end

    // Result decode, purely from the accumulated directory state.
    logic [num_lce_p-1:0] req_oh;
    logic [num_lce_p-1:0] oth;
    logic                 req_hit;
    logic                 req_shared;
    logic [way_w-1:0]     req_way;
    logic [lce_idx_w-1:0] owner_idx;
    logic [way_w-1:0]     owner_way;
    logic [cnt_w-1:0]     sharer_cnt;

    always_comb begin
        req_oh     = '0;
        req_hit    = 1'b0;
        req_shared = 1'b0;
        req_way    = '0;
        for (int i = 0; i < num_lce_p; i++) begin
            if (lce_idx_w'(i) == req_idx_q) begin
                req_oh[i]  = 1'b1;
                req_hit    = hit_q[i];
                req_shared = shared_q[i];
                if (hit_q[i]) begin
                    req_way = way_q[i];
                end
            end
        end

        oth = hit_q & ~req_oh;

        // Scan downward so the lowest-index owner is the one that sticks.
        owner_idx = '0;
        owner_way = '0;
        for (int i = num_lce_p - 1; i >= 0; i--) begin
            if (oth[i] && owned_q[i]) begin
                owner_idx = lce_idx_w'(i);
                owner_way = way_q[i];
            end
        end

        sharer_cnt = '0;
        for (int i = 0; i < num_lce_p; i++) begin
            sharer_cnt = sharer_cnt + cnt_w'(oth[i]);
        end
    end

    logic dg_en;
    assign dg_en = 1'(downgrade_en_p != 0);

    assign start_ready_o           = start_ready_q;
    assign row_ready_o             = row_ready_q;
    assign v_o                     = v_q;

    assign cached_flag_o           = |oth;
    assign cached_exclusive_flag_o = |(oth & ~shared_q);
    assign cached_owned_flag_o     = |(oth & owned_q);
    assign cached_dirty_flag_o     = |(oth & dirty_q);
    assign transfer_flag_o         = cached_owned_flag_o;
    assign upgrade_flag_o          = req_wr_q & req_hit & req_shared;
    assign replacement_flag_o      = ~upgrade_flag_o & lru_cached_excl_q & lru_dirty_q;
    assign downgrade_flag_o        = dg_en & ~req_wr_q & cached_owned_flag_o;
    // A downgraded owner keeps its copy, so it is not an invalidation target.
    assign invalidate_flag_o       = req_wr_q ? cached_flag_o
                                              : (cached_exclusive_flag_o & ~downgrade_flag_o);
    assign inv_lce_o               = !invalidate_flag_o ? '0
                                   : req_wr_q ? oth
                                   : (oth & ~shared_q);

    assign req_addr_way_o          = req_way;
    assign owner_lce_o             = lce_id_width_p'(owner_idx);
    assign owner_way_o             = owner_way;
    assign sharer_cnt_o            = sharer_cnt;

endmodule

// File: doc/bp_cce_gad_stream.md
# bp_cce_gad_stream

Streaming, parametrised successor to the CCE's combinational GAD logic. It accepts a coherence request context, consumes the way-group's per-LCE directory entries as a sequence of row beats (`row_width_p` LCEs per beat), accumulates hit, way and state information, then presents the GAD result until the CCE pops it. It adds three things the combinational GAD lacks:
- an optional owner-downgrade mode for reads;
- an explicit per-LCE invalidation target vector;
- a sharer count.

## Interface
- num_lce_p, 8: number of LCEs tracked.
- lce_assoc_p, 8: LCE associativity; way_w = clog2(lce_assoc_p).
- lce_id_width_p, 4: LCE ID width; the low clog2(num_lce_p) bits index LCEs.
- row_width_p, 2: LCE entries per directory row beat; rows_lp = ceil(num_lce_p/row_width_p).
- downgrade_en_p, 1: 1 = reads downgrade the owner instead of invalidating it.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous, active-low reset.
- start_v_i  in  1  request context valid.
- start_ready_o  out  1  block idle, context accepted.
- req_lce_i  in  lce_id_width_p  requesting LCE.
- req_wr_i  in  1  1 = write request.
- lru_dirty_i  in  1  LRU block dirty.
- lru_cached_excl_i  in  1  LRU block cached exclusive.
- row_v_i  in  1  directory row beat valid.
- row_ready_o  out  1  row beat accepted.
- row_hits_i  in  row_width_p  per-entry hit.
- row_ways_i  in  row_width_p*way_w  per-entry way.
- row_states_i  in  row_width_p*3  per-entry coherence state; bit0 = shared, bit1 = owned, bit2 = dirty.
- v_o  out  1  result valid.
- yumi_i  in  1  result consumed; legal only while v_o=1.
- req_addr_way_o  out  way_w  requester's way on hit, else 0.
- owner_lce_o  out  lce_id_width_p  owner LCE (zero-extended).
- owner_way_o  out  way_w  owner's way.
- transfer_flag_o, replacement_flag_o, upgrade_flag_o, invalidate_flag_o, downgrade_flag_o  out  1 each.
- cached_flag_o, cached_exclusive_flag_o, cached_owned_flag_o, cached_dirty_flag_o  out  1 each.
- inv_lce_o  out  num_lce_p  LCEs to invalidate.
- sharer_cnt_o  out  clog2(num_lce_p+1)  number of non-requester LCEs that hit.

## Operation
FSM with states IDLE, SCAN, DONE.
- **IDLE:**
  - start_ready_o=1.
  - On start_v_i, capture req_lce, req_wr, lru_dirty and lru_cached_excl.
  - Clear all hit/way/state accumulators and set row_cnt=0, then go to SCAN.
- **SCAN:**
  - row_ready_o=1.
  - Each accepted beat writes entry j into LCE index row_cnt*row_width_p+j. Entries whose index is ≥ num_lce_p are ignored.
  - row_cnt increments on each accepted beat.
  - The beat accepted with row_cnt==rows_lp-1 moves the FSM to DONE.
- **DONE:**
  - v_o=1 and all outputs are held stable.
  - yumi_i returns the FSM to IDLE. Accumulators are not cleared until the next start.
- row_v_i outside SCAN and start_v_i outside IDLE are ignored (not consumed).

Definitions. Let oth = hit & ~onehot(req), computed over the accumulated vectors.
- cached_flag_o = |oth.
- cached_exclusive_flag_o = |(oth & ~shared).
- cached_owned_flag_o = |(oth & owned).
- cached_dirty_flag_o = |(oth & dirty).
- transfer_flag_o = cached_owned_flag_o.
- Owner: the lowest-index LCE in oth & owned. owner_lce_o and owner_way_o are 0 when transfer_flag_o=0.
- upgrade_flag_o = req_wr & hit[req] & shared[req].
- replacement_flag_o = ~upgrade & lru_cached_excl & lru_dirty.
- downgrade_flag_o = downgrade_en_p & ~req_wr & cached_owned_flag_o.
- invalidate_flag_o:
  - cached_flag_o when req_wr=1;
  - cached_exclusive_flag_o & ~downgrade_flag_o when req_wr=0.
- inv_lce_o:
  - 0 when invalidate_flag_o=0;
  - oth when req_wr=1;
  - oth & ~shared when req_wr=0.
- sharer_cnt_o = popcount(oth).

## Timing
- Reset (reset_n_i=0 at a clock edge) has these effects:
  - FSM goes to IDLE and every accumulator and captured field is cleared.
  - All outputs read 0 except start_ready_o=1.
  - Reset mid-SCAN or mid-DONE abandons the operation; no v_o follows.
- Latency: with start accepted at edge 0 and rows accepted back-to-back at edges 1..rows_lp, v_o=1 from the cycle after edge rows_lp.
- Row stalls (row_v_i=0) add cycles one-for-one.
- yumi_i together with start_v_i in the same cycle: the start is not accepted that cycle, because start_ready_o=0 in DONE. The start is accepted the following cycle.
- Outputs are derived from registered state only; there is no combinational path from row_* or start_* to any output.
- Back-to-back throughput: one request per rows_lp+2 cycles.

## Test plan
- num_lce_p=8, row_width_p=2, downgrade_en_p=0. Read from LCE 0; LCE 5 is in M (state 3'b110, way 3); all others miss. Required: after 4 row beats, v_o=1 with:
  - transfer=1, owner_lce_o=5, owner_way_o=3, invalidate=1, inv_lce_o=8'b0010_0000, sharer_cnt_o=1.
- Same stimulus with downgrade_en_p=1. Required: downgrade=1, invalidate=0, inv_lce_o=0, transfer=1.
- Write from LCE 2, which holds S at way 4; LCEs 1 and 6 hold S. Required:
  - upgrade=1, replacement=0, req_addr_way_o=4, invalidate=1, inv_lce_o=8'b0100_0010, sharer_cnt_o=2.
- num_lce_p=5, row_width_p=2 (3 rows, last entry ignored). A hit in the padded slot with state M must produce cached_flag_o=0 and v_o exactly 1 cycle after the third beat.
- Row stalls: insert 2 idle cycles between beats and hold yumi_i low 3 cycles. Required:
  - v_o holds all outputs stable;
  - a start_v_i asserted during DONE is not taken until the cycle after yumi_i.
- Assert reset_n_i=0 after 2 row beats, then run a new all-miss read. Required: the result has all flags 0, sharer_cnt_o=0 and owner_lce_o=0, with no stale hits.
